// File: rtl/m_div_iter.sv
// m_div_iter: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; optional early-out under M_DIV_EARLY_OUT_EN
module m_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      op_q;
  logic            qneg_q, rneg_q, dz_q, busy_q, done_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, result_q;
  logic [XLEN-1:0] rem_d, quo_d, q_fix, res_fix, a_abs, b_abs;
  logic [XLEN:0]   rem_sh, diff;
  logic            signed_op, a_neg, b_neg;
`ifdef M_DIV_EARLY_OUT_EN
  logic            special;
  logic [XLEN-1:0] sp_res;
`endif
  // One restoring step, sign/zero fix-up, and operand conditioning at accept time
  always_comb begin
    rem_sh    = {rem_q, quo_q[XLEN-1]};
    diff      = rem_sh - {1'b0, dvs_q};
    rem_d     = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    quo_d     = {quo_q[XLEN-2:0], ~diff[XLEN]};
    q_fix     = dz_q ? '1 : (qneg_q ? -quo_q : quo_q);
    res_fix   = op_q[1] ? (rneg_q ? -rem_q : rem_q) : q_fix;
    signed_op = ~op[0];
    a_neg     = signed_op & dividend[XLEN-1];
    b_neg     = signed_op & divisor[XLEN-1];
    a_abs     = a_neg ? -dividend : dividend;
    b_abs     = b_neg ? -divisor : divisor;
`ifdef M_DIV_EARLY_OUT_EN
    special   = (divisor == '0) |
                (signed_op & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (&divisor));
    sp_res    = (divisor == '0) ? (op[1] ? dividend : '1) : (op[1] ? '0 : dividend);
`endif
  end
  // Control FSM with registered busy/done and the datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          op_q   <= op;
          qneg_q <= a_neg ^ b_neg;
          rneg_q <= a_neg;
          dz_q   <= divisor == '0;
          quo_q  <= a_abs;
          dvs_q  <= b_abs;
          rem_q  <= '0;
          cnt_q  <= '0;
          busy_q <= 1'b1;
`ifdef M_DIV_EARLY_OUT_EN
          if (special) begin
            result_q <= sp_res;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            state_q  <= CALC;
          end
`else
          state_q <= CALC;
`endif
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) state_q <= FIX;
        end
        FIX: begin
          result_q <= res_fix;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_m_div_iter.sv
// tb_m_div_iter: scoreboard bench for m_div_iter; directed vectors plus a short modelled random run
module tb_m_div_iter;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        busy, done;
  logic [31:0] result;
  int          cyc = 0, tests = 0, fails = 0;
  typedef struct {logic [31:0] res; int dc;} exp_t;
  exp_t q[$];

  m_div_iter #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int lat(logic [1:0] o, logic [31:0] a, logic [31:0] b);
`ifdef M_DIV_EARLY_OUT_EN
    if (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] model(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return o[1] ? a % b : a / b;
  endfunction

  // monitor: every done pulse must match the oldest expectation, in value and cycle
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done=1 with no pending op, result %h (cycle %0d)", result, cyc);
      end else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", cyc, e.dc);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 120 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d done pulses missing, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic issue(logic [1:0] o, logic [31:0] a, logic [31:0] b, logic [31:0] r);
    @(negedge clk);
    op = o; dividend = a; divisor = b; start = 1'b1;
    q.push_back('{r, cyc + lat(o, a, b)});
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    wait_idle();
  endtask

  initial begin
    int c0;
    logic [1:0]  o;
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_done", {31'b0, done}, 0);
    chk("reset_result", result, 0);
    reset = 1'b0;
    issue(2'b11, 32'd7, 32'd2, 32'd1);
    @(negedge clk);
    op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1; c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_busy", {31'b0, busy}, 0);
    chk("midreset_result", result, 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(2'b01, 32'd100, 32'd7, 32'd14);
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    issue(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
    issue(2'b10, 32'd5, 32'd0, 32'd5);
    issue(2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
    issue(2'b11, 32'd5, 32'd0, 32'd5);
    issue(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    issue(2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
    issue(2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
    issue(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    @(negedge clk);
    op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1; c0 = cyc;
    q.push_back('{32'd14, c0 + 34});
    q.push_back('{32'hFFFF_FFFD, c0 + 69});
    @(negedge clk);
    op = 2'b00; dividend = 32'hFFFF_FFF9; divisor = 32'd2;
    while (cyc < c0 + 35) @(negedge clk);
    chk("busy_cycle35", {31'b0, busy}, 0);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    for (int i = 0; i < 200; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = -$urandom_range(1, 15);
        4: a = $urandom_range(0, 20);
        default: ;
      endcase
      issue(o, a, b, model(o, a, b));
    end
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
